pos_pid_sat: RTL and testbench
==============================

// Module: pos_pid_sat
// PURPOSE
//  Parametrised, saturating incremental (velocity-form) position PID for the galvo loop.
//  Accepts one setpoint/ADC sample per sample_valid strobe and runs a fixed 4-edge FSM pipeline.
//  Produces a clamped DAC code with a one-cycle dac_valid strobe.
//  Sits between the position ADC interface and the DAC driver. Math is signed with no silent wrap.
// PARAMETERS
//  DW      16      data width of pos_pre/pos_adc/pos_dac, signed two's complement
//  GW      16      gain width of kp/ki/kd, unsigned
//  FRAC    16      fractional bits in gains; products are arithmetically shifted right by FRAC
//  OUT_MIN -32768  lower clamp of pos_dac, signed DW-bit
//  OUT_MAX 32767   upper clamp of pos_dac, signed DW-bit; OUT_MIN < OUT_MAX required
// PORTS
//  clk_pid      in   1   PID clock
//  sys_rstn     in   1   reset, asynchronous, active-low
//  en           in   1   loop enable; low = hold output, flush history
//  sample_valid in   1   new pos_pre/pos_adc sample strobe
//  pos_pre      in   DW  position setpoint, signed
//  pos_adc      in   DW  measured position, signed
//  kp, ki, kd   in   GW  gains, unsigned, Q(GW-FRAC).FRAC
//  ovr_clr      in   1   clears ovr_flag
//  pos_dac      out  DW  clamped controller output, signed
//  dac_valid    out  1   one-cycle strobe: pos_dac updated this cycle
//  sat_hi       out  1   last result clamped at OUT_MAX
//  sat_lo       out  1   last result clamped at OUT_MIN
//  busy         out  1   FSM not in IDLE
//  ovr_flag     out  1   sticky: sample_valid seen while busy
// BEHAVIOUR
//  Reset: pos_dac=0 (clamped into range), dac_valid=0, sat_hi=sat_lo=0, busy=0, ovr_flag=0.
//   Reset also clears e1, e2, u_prev and sets state IDLE. Reset mid-pipeline discards the sample.
//  FSM: IDLE -> ERR -> MUL -> ACC -> IDLE.
//   Edge N, IDLE & en & sample_valid: register pos_pre/pos_adc, go ERR.
//   ERR: e = pre - adc in DW+1 bits (no wrap). Register e, d1 = e-e1, d2 = e-2*e1+e2 (DW+3 bits).
//   MUL: register p = kp*d1, i = ki*e, d = kd*d2 (signed, GW+DW+4 bits).
//   ACC: acc = u_prev + (p>>>FRAC) + (i>>>FRAC) + (d>>>FRAC), width GW+DW+6.
//    Clamp acc to [OUT_MIN, OUT_MAX], then register pos_dac, sat_hi/sat_lo and u_prev.
//    u_prev takes the CLAMPED value (anti-windup). e2<=e1, e1<=e. dac_valid<=1. Go IDLE.
//  Latency: pos_dac and dac_valid are valid in the cycle after edge N+3. Throughput is one sample per 4 cycles.
//  sample_valid at edges N+1..N+3 is ignored and sets ovr_flag.
//   ovr_clr clears ovr_flag; an overrun on the same edge wins (flag stays 1).
//  >>> is an arithmetic shift (floor toward -inf). Gains are zero-extended before the signed multiply.
//  en low: state forced IDLE at the next edge, in-flight sample dropped, e1=e2=0.
//   pos_dac, sat_hi and sat_lo hold; u_prev = pos_dac; no dac_valid.
//   When en rises, the first sample sees history = 0.
//  kp/ki/kd are sampled in MUL. A gain change takes effect on the next sample that reaches MUL.
// CONFIGURATION
//  POS_PID_DEADBAND_EN defined: adds port deadband in DW (unsigned) after ovr_clr.
//   In ERR, if |e| <= deadband then e is forced to 0 before d1/d2 and history are computed.
//  Not defined: no deadband port; e is used as computed.
// TESTING (FRAC=16, default clamps unless noted)
//  1 I-only: ki=0x8000, kp=kd=0, pre=100, adc=0, three strobes -> pos_dac 50, 100, 150.
//    Each dac_valid comes 4 edges after its strobe.
//  2 P step: kp=0x8000, pre steps 0 -> 200, two strobes -> pos_dac 100 then 100 (delta term 0 on the 2nd).
//  3 D: kd=0x8000, e sequence 0, 200, 200, 200 -> increments 0, +100, -100, 0.
//  4 Saturate/anti-windup: ki=0xFFFF, pre=32767, adc=-32768 -> pos_dac=32767, sat_hi=1.
//    Then pre=-32768, adc=32767 -> pos_dac=-32768, sat_lo=1 (u_prev was clamped).
//  5 Overrun: strobe at edge N and again at N+2 -> one dac_valid only, ovr_flag=1.
//    ovr_clr pulse -> ovr_flag=0.
//  6 en low at edge N+1, then sys_rstn low mid-pipeline -> no dac_valid, outputs hold.
//    After reset all outputs = 0 and the next sample uses history = 0.

Source files
------------

// File: rtl/pos_pid_sat.sv
// Saturating incremental (velocity-form) position PID: IDLE -> ERR -> MUL -> ACC pipeline, clamped DAC output.
// Optional deadband input and error deadband enabled by defining POS_PID_DEADBAND_EN.
module pos_pid_sat #(
    parameter int DW      = 16,
    parameter int GW      = 16,
    parameter int FRAC    = 16,
    parameter int OUT_MIN = -32768,
    parameter int OUT_MAX = 32767
) (
    input  logic          clk_pid,
    input  logic          sys_rstn,
    input  logic          en,
    input  logic          sample_valid,
    input  logic [DW-1:0] pos_pre,
    input  logic [DW-1:0] pos_adc,
    input  logic [GW-1:0] kp,
    input  logic [GW-1:0] ki,
    input  logic [GW-1:0] kd,
    input  logic          ovr_clr,
`ifdef POS_PID_DEADBAND_EN
    input  logic [DW-1:0] deadband,
`endif
    output logic [DW-1:0] pos_dac,
    output logic          dac_valid,
    output logic          sat_hi,
    output logic          sat_lo,
    output logic          busy,
    output logic          ovr_flag
);

    localparam int EW = DW + 1;
    localparam int XW = DW + 3;
    localparam int PW = GW + DW + 4;
    localparam int AW = GW + DW + 6;

    localparam logic signed [AW-1:0] ACC_MIN = AW'(OUT_MIN);
    localparam logic signed [AW-1:0] ACC_MAX = AW'(OUT_MAX);
    localparam int                   RST_VAL = (OUT_MIN > 0) ? OUT_MIN : ((OUT_MAX < 0) ? OUT_MAX : 0);
    localparam logic signed [DW-1:0] RST_DAC = DW'(RST_VAL);

    typedef enum logic [1:0] {IDLE, ERR, MUL, ACC} state_t;

    state_t               state_q;
    logic signed [DW-1:0] pre_q, adc_q, pos_dac_q, u_prev_q;
    logic signed [EW-1:0] e_q, e1_q, e2_q;
    logic signed [XW-1:0] d1_q, d2_q;
    logic signed [PW-1:0] p_q, i_q, d_q;
    logic                 dac_valid_q, sat_hi_q, sat_lo_q, ovr_q;

    logic signed [EW-1:0] e_raw, e_d;
    logic signed [XW-1:0] d1_d, d2_d;
    logic signed [PW-1:0] p_d, i_d, d_d;
    logic signed [AW-1:0] acc;
    logic signed [DW-1:0] dac_d;
    logic                 sat_hi_d, sat_lo_d;
`ifdef POS_PID_DEADBAND_EN
    logic        [EW-1:0] e_abs;
`endif

    always_comb begin
        e_raw = EW'(pre_q) - EW'(adc_q);
`ifdef POS_PID_DEADBAND_EN
        e_abs = e_raw[EW-1] ? -e_raw : e_raw;
        e_d   = (e_abs <= {1'b0, deadband}) ? '0 : e_raw;
`else
        e_d   = e_raw;
`endif
        d1_d = XW'(e_d) - XW'(e1_q);
        d2_d = XW'(e_d) - XW'(e1_q) - XW'(e1_q) + XW'(e2_q);
    end

    // Gains are zero-extended one bit so the multiply stays signed.
    always_comb begin
        p_d = PW'($signed({1'b0, kp})) * PW'(d1_q);
        i_d = PW'($signed({1'b0, ki})) * PW'(e_q);
        d_d = PW'($signed({1'b0, kd})) * PW'(d2_q);
    end

    always_comb begin
        acc      = AW'(u_prev_q) + AW'(p_q >>> FRAC) + AW'(i_q >>> FRAC) + AW'(d_q >>> FRAC);
        sat_hi_d = 1'b0;
        sat_lo_d = 1'b0;
        if (acc >= ACC_MAX) begin
            dac_d    = DW'(OUT_MAX);
            sat_hi_d = 1'b1;
        end else if (acc <= ACC_MIN) begin
            dac_d    = DW'(OUT_MIN);
            sat_lo_d = 1'b1;
        end else begin
            dac_d    = acc[DW-1:0];
        end
    end

    always_ff @(posedge clk_pid or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q     <= IDLE;
            pre_q       <= '0;
            adc_q       <= '0;
            e_q         <= '0;
            e1_q        <= '0;
            e2_q        <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            p_q         <= '0;
            i_q         <= '0;
            d_q         <= '0;
            u_prev_q    <= '0;
            pos_dac_q   <= RST_DAC;
            dac_valid_q <= 1'b0;
            sat_hi_q    <= 1'b0;
            sat_lo_q    <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            dac_valid_q <= 1'b0;
            ovr_q       <= (ovr_q & ~ovr_clr) | (sample_valid & (state_q != IDLE));
            if (!en) begin
                state_q  <= IDLE;
                e1_q     <= '0;
                e2_q     <= '0;
                u_prev_q <= pos_dac_q;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (sample_valid) begin
                            pre_q   <= pos_pre;
                            adc_q   <= pos_adc;
                            state_q <= ERR;
                        end
                    end
                    ERR: begin
                        e_q     <= e_d;
                        d1_q    <= d1_d;
                        d2_q    <= d2_d;
                        state_q <= MUL;
                    end
                    MUL: begin
                        p_q     <= p_d;
                        i_q     <= i_d;
                        d_q     <= d_d;
                        state_q <= ACC;
                    end
                    ACC: begin
                        // u_prev follows the clamped output so the integrator cannot wind up.
                        pos_dac_q   <= dac_d;
                        u_prev_q    <= dac_d;
                        sat_hi_q    <= sat_hi_d;
                        sat_lo_q    <= sat_lo_d;
                        e2_q        <= e1_q;
                        e1_q        <= e_q;
                        dac_valid_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign pos_dac   = pos_dac_q;
    assign dac_valid = dac_valid_q;
    assign sat_hi    = sat_hi_q;
    assign sat_lo    = sat_lo_q;
    assign busy      = (state_q != IDLE);
    assign ovr_flag  = ovr_q;

endmodule

// File: tb/tb_pos_pid_sat.sv
// Directed plus randomized bench for pos_pid_sat against an arithmetic reference model (default parameters).
module tb_pos_pid_sat;

    logic        clk_pid = 1'b0;
    logic        sys_rstn = 1'b1;
    logic        en = 1'b0;
    logic        sample_valid = 1'b0;
    logic        ovr_clr = 1'b0;
    logic [15:0] pos_pre = '0;
    logic [15:0] pos_adc = '0;
    logic [15:0] kp = '0;
    logic [15:0] ki = '0;
    logic [15:0] kd = '0;
    logic [15:0] pos_dac;
    logic        dac_valid, sat_hi, sat_lo, busy, ovr_flag;

    int     tests = 0;
    int     fails = 0;
    longint m_e1, m_e2, m_u;
    logic   m_hi, m_lo;
    longint held;

    pos_pid_sat #(.DW(16), .GW(16), .FRAC(16), .OUT_MIN(-32768), .OUT_MAX(32767)) dut (
        .clk_pid     (clk_pid),
        .sys_rstn    (sys_rstn),
        .en          (en),
        .sample_valid(sample_valid),
        .pos_pre     (pos_pre),
        .pos_adc     (pos_adc),
        .kp          (kp),
        .ki          (ki),
        .kd          (kd),
        .ovr_clr     (ovr_clr),
`ifdef POS_PID_DEADBAND_EN
        .deadband    (16'd0),
`endif
        .pos_dac     (pos_dac),
        .dac_valid   (dac_valid),
        .sat_hi      (sat_hi),
        .sat_lo      (sat_lo),
        .busy        (busy),
        .ovr_flag    (ovr_flag)
    );

    always #5 clk_pid = ~clk_pid;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint fl(input longint x);
        if (x >= 0) return x / 65536;
        return -((-x + 65535) / 65536);
    endfunction

    task automatic model_reset();
        m_e1 = 0; m_e2 = 0; m_u = 0; m_hi = 1'b0; m_lo = 1'b0;
    endtask

    task automatic model_sample(input longint pre, input longint adc);
        longint e, d1, d2, acc;
        e   = pre - adc;
        d1  = e - m_e1;
        d2  = e - 2 * m_e1 + m_e2;
        acc = m_u + fl(longint'(kp) * d1) + fl(longint'(ki) * e) + fl(longint'(kd) * d2);
        m_hi = (acc >= 32767);
        m_lo = (acc <= -32768);
        m_u  = m_hi ? 32767 : (m_lo ? -32768 : acc);
        m_e2 = m_e1;
        m_e1 = e;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".dac"},   $signed(pos_dac), m_u);
        check({tag, ".sathi"}, sat_hi, m_hi);
        check({tag, ".satlo"}, sat_lo, m_lo);
    endtask

    // One sample: strobe before edge N, result expected just after edge N+3.
    task automatic run_sample(input logic signed [15:0] pre, input logic signed [15:0] adc, input string tag);
        @(negedge clk_pid);
        pos_pre = pre; pos_adc = adc; sample_valid = 1'b1;
        @(negedge clk_pid);
        sample_valid = 1'b0;
        check({tag, ".busy"}, busy, 1);
        @(negedge clk_pid);
        @(negedge clk_pid);
        check({tag, ".early"}, dac_valid, 0);
        @(negedge clk_pid);
        model_sample(longint'(pre), longint'(adc));
        check({tag, ".dv"}, dac_valid, 1);
        check({tag, ".idle"}, busy, 0);
        check_outputs(tag);
        @(negedge clk_pid);
        check({tag, ".dvpulse"}, dac_valid, 0);
    endtask

    task automatic do_reset();
        @(negedge clk_pid);
        #2 sys_rstn = 1'b0;
        #1;
        @(negedge clk_pid);
        sys_rstn = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        #2 sys_rstn = 1'b0;
        #1;
        check("rst.dac", $signed(pos_dac), 0);
        check("rst.dv", dac_valid, 0);
        check("rst.sathi", sat_hi, 0);
        check("rst.satlo", sat_lo, 0);
        check("rst.busy", busy, 0);
        check("rst.ovr", ovr_flag, 0);
        @(negedge clk_pid);
        sys_rstn = 1'b1;
        en = 1'b1;

        // I-only ramp
        ki = 16'h8000;
        run_sample(16'sd100, 16'sd0, "i1");
        check("i1.lit", $signed(pos_dac), 50);
        run_sample(16'sd100, 16'sd0, "i2");
        check("i2.lit", $signed(pos_dac), 100);
        run_sample(16'sd100, 16'sd0, "i3");
        check("i3.lit", $signed(pos_dac), 150);

        // P step
        do_reset();
        ki = 16'h0; kp = 16'h8000;
        run_sample(16'sd200, 16'sd0, "p1");
        check("p1.lit", $signed(pos_dac), 100);
        run_sample(16'sd200, 16'sd0, "p2");
        check("p2.lit", $signed(pos_dac), 100);

        // D term on error 0, 200, 200, 200
        do_reset();
        kp = 16'h0; kd = 16'h8000;
        run_sample(16'sd0, 16'sd0, "d1");
        check("d1.lit", $signed(pos_dac), 0);
        run_sample(16'sd200, 16'sd0, "d2");
        check("d2.lit", $signed(pos_dac), 100);
        run_sample(16'sd200, 16'sd0, "d3");
        check("d3.lit", $signed(pos_dac), 0);
        run_sample(16'sd200, 16'sd0, "d4");
        check("d4.lit", $signed(pos_dac), 0);

        // Saturation and anti-windup
        do_reset();
        kd = 16'h0; ki = 16'hFFFF;
        run_sample(16'sh7FFF, 16'sh8000, "s1");
        check("s1.lit", $signed(pos_dac), 32767);
        check("s1.hi", sat_hi, 1);
        run_sample(16'sh8000, 16'sh7FFF, "s2");
        check("s2.lit", $signed(pos_dac), -32768);
        check("s2.lo", sat_lo, 1);
        check("s2.hi", sat_hi, 0);

        // Overrun: second strobe two edges after the first is ignored
        do_reset();
        ki = 16'h8000;
        @(negedge clk_pid); pos_pre = 16'sd100; pos_adc = 16'sd0; sample_valid = 1'b1;
        @(negedge clk_pid); sample_valid = 1'b0;
        @(negedge clk_pid); sample_valid = 1'b1;
        @(negedge clk_pid); sample_valid = 1'b0;
        check("ovr.set", ovr_flag, 1);
        check("ovr.early", dac_valid, 0);
        @(negedge clk_pid);
        model_sample(100, 0);
        check("ovr.dv", dac_valid, 1);
        check_outputs("ovr");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_pid);
            check("ovr.nodv", dac_valid, 0);
        end
        ovr_clr = 1'b1;
        @(negedge clk_pid); ovr_clr = 1'b0;
        check("ovr.clr", ovr_flag, 0);
        // Overrun on the same edge as ovr_clr keeps the flag
        @(negedge clk_pid); sample_valid = 1'b1;
        @(negedge clk_pid); sample_valid = 1'b0;
        @(negedge clk_pid); sample_valid = 1'b1; ovr_clr = 1'b1;
        @(negedge clk_pid); sample_valid = 1'b0; ovr_clr = 1'b0;
        check("ovr.win", ovr_flag, 1);
        @(negedge clk_pid);
        model_sample(100, 0);
        check("ovr2.dv", dac_valid, 1);
        check_outputs("ovr2");
        ovr_clr = 1'b1;
        @(negedge clk_pid); ovr_clr = 1'b0;
        check("ovr2.clr", ovr_flag, 0);

        // en low at edge N+1 drops the sample and flushes history
        held = m_u;
        @(negedge clk_pid); pos_pre = 16'sd300; pos_adc = 16'sd0; sample_valid = 1'b1;
        @(negedge clk_pid); sample_valid = 1'b0; en = 1'b0;
        @(negedge clk_pid); en = 1'b1;
        m_e1 = 0; m_e2 = 0;
        check("en.busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_pid);
            check("en.nodv", dac_valid, 0);
            check("en.hold", $signed(pos_dac), held);
        end
        // Asynchronous reset mid-pipeline
        @(negedge clk_pid); pos_pre = 16'sd500; pos_adc = 16'sd0; sample_valid = 1'b1;
        @(negedge clk_pid); sample_valid = 1'b0;
        @(negedge clk_pid);
        #2 sys_rstn = 1'b0;
        #1;
        check("mrst.dac", $signed(pos_dac), 0);
        check("mrst.busy", busy, 0);
        check("mrst.dv", dac_valid, 0);
        @(negedge clk_pid); sys_rstn = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_pid);
            check("mrst.nodv", dac_valid, 0);
        end
        run_sample(16'sd500, 16'sd0, "post");
        check("post.lit", $signed(pos_dac), 250);

        // Randomized samples, gains and enable gaps
        do_reset();
        for (int n = 0; n < 40; n++) begin
            kp = 16'($urandom_range(0, 65535));
            ki = 16'($urandom_range(0, 65535));
            kd = 16'($urandom_range(0, 65535));
            if (($urandom % 8) == 0) begin
                @(negedge clk_pid); en = 1'b0;
                @(negedge clk_pid); en = 1'b1;
                m_e1 = 0; m_e2 = 0;
            end
            if (($urandom % 2) == 0)
                run_sample(16'($urandom), 16'($urandom), "rnd");
            else
                run_sample(16'($signed(17'($urandom_range(0, 2000)) - 17'sd1000)),
                           16'($signed(17'($urandom_range(0, 2000)) - 17'sd1000)), "rndsm");
            check("rnd.ovr", ovr_flag, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
